mult_div_unit: RTL
==================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and HI/LO width.
REQ-002 SHALL have parameter CNT_W, default 6, iteration counter width (must hold WIDTH+1).
REQ-003 SHALL have port CLK  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port SrcA  input  WIDTH  operand A (register-file RD1): multiplicand/dividend.
REQ-006 SHALL have port SrcB  input  WIDTH  operand B (register-file RD2): multiplier/divisor.
REQ-007 SHALL have port Op  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-008 SHALL have port Start  input  1  launch request, sampled on rising edge.
REQ-009 SHALL have port HI_WE, LO_WE  input  1 each  direct HI/LO writes (MTHI/MTLO).
REQ-010 SHALL have port WD  input  WIDTH  data for HI_WE/LO_WE.
REQ-011 SHALL have port Busy  output  1  operation in progress.
REQ-012 SHALL have port Done  output  1  one-cycle completion pulse.
REQ-013 SHALL have port HI, LO  output  WIDTH each  registered result registers (MFHI/MFLO source).

Function
REQ-014 SHALL implement FSM IDLE -> RUN -> FIN -> IDLE.
REQ-015 IDLE: Start=1 SHALL latch SrcA, SrcB, Op, clear counter, go RUN; Busy=1 from the next cycle.
REQ-016 RUN: one iteration per cycle, exactly WIDTH cycles; counter increments; at count WIDTH-1 go FIN.
REQ-017 Multiply SHALL be shift-add on magnitudes into a 2*WIDTH accumulator.
REQ-018 Divide SHALL be restoring, one quotient bit per cycle, on magnitudes.
REQ-019 FIN: HI/LO SHALL load the final result at the FIN edge; Busy SHALL deassert and Done SHALL be 1 for exactly the following cycle.
REQ-020 Latency: Start sampled at edge N -> HI/LO valid and Done=1 after edge N+WIDTH+1 (33 for WIDTH=32).
REQ-021 MULT/MULTU: {HI,LO} = 2*WIDTH-bit signed/unsigned product.
REQ-022 DIV/DIVU: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
REQ-023 Signed ops: operands negated to magnitudes at latch; result signs fixed at FIN.
REQ-024 Divide by zero: full latency; LO = all ones, HI = SrcA as latched.
REQ-025 DIV of most-negative by -1: LO = 0x80000000, HI = 0 (WIDTH=32), no error.
REQ-026 Start while Busy SHALL be ignored; the running operation is unaffected.
REQ-027 HI_WE/LO_WE in IDLE SHALL write WD to HI/LO at that edge; both may be set together.
REQ-028 HI_WE/LO_WE while Busy, or in the same cycle as an accepted Start, SHALL be ignored (Start wins).
REQ-029 HI/LO SHALL hold their values at all times except per REQ-019 and REQ-027.
REQ-030 Operand inputs SHALL be don't-care after the Start edge.

Reset
REQ-031 RST=1 at a rising edge SHALL force IDLE and set HI=0, LO=0, Busy=0, Done=0, counter=0.
REQ-032 RST mid-operation SHALL abort the operation; no Done pulse; HI/LO=0.
REQ-033 RST SHALL take priority over Start, HI_WE and LO_WE in the same cycle.

Verification
REQ-034 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> after 33 cycles HI=0xFFFFFFFE, LO=0x00000001, Done one cycle.
REQ-035 MULT -3 x 7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; DIV -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-036 DIVU 100 / 0 -> LO=0xFFFFFFFF, HI=100 after 33 cycles; DIV 0x80000000 / -1 -> LO=0x80000000, HI=0.
REQ-037 Start MULTU 2x3 with a second Start at cycle 5 and LO_WE at cycle 10 -> single Done, HI=0, LO=6.
REQ-038 Idle HI_WE=1, LO_WE=1, WD=0xA5A5A5A5 -> both read 0xA5A5A5A5 next cycle; Start+HI_WE same cycle -> HI from result only.
REQ-039 RST asserted at cycle 12 of a divide -> Busy=0, HI=LO=0, no Done; a new Start then completes normally.

Source files
------------

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit: shift-add multiply, restoring divide, HI/LO result registers.
// Latency: Start at edge N -> HI/LO loaded and Done=1 after edge N+WIDTH+1; Start is ignored while Busy.
module mult_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic [1:0]       Op,
    input  logic             Start,
    input  logic             HI_WE,
    input  logic             LO_WE,
    input  logic [WIDTH-1:0] WD,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 is_div_q, is_div_d;
    logic                 neg_a_q, neg_a_d;
    logic                 neg_b_q, neg_b_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 done_q, done_d;

    logic [WIDTH-1:0]     src_a_mag, src_b_mag;
    logic [WIDTH:0]       mul_sum, div_shift;
    logic [WIDTH-1:0]     div_rem, quo, rem;
    logic                 div_ge;
    logic [2*WIDTH-1:0]   prod;

    always_comb begin
        src_a_mag = (Op[0] && SrcA[WIDTH-1]) ? -SrcA : SrcA;
        src_b_mag = (Op[0] && SrcB[WIDTH-1]) ? -SrcB : SrcB;

        // Multiply: acc = {partial product, remaining multiplier bits}
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);

        // Divide: acc = {partial remainder, dividend bits shifting into quotient}
        div_shift = acc_q[2*WIDTH-1:WIDTH-1];
        div_ge    = div_shift >= {1'b0, b_q};
        div_rem   = div_ge ? (div_shift[WIDTH-1:0] - b_q) : div_shift[WIDTH-1:0];

        prod = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
        quo  = (neg_a_q ^ neg_b_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem  = neg_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    is_div_d = Op[1];
                    neg_a_d  = Op[0] & SrcA[WIDTH-1];
                    neg_b_d  = Op[0] & SrcB[WIDTH-1];
                    a_d      = src_a_mag;
                    b_d      = src_b_mag;
                    acc_d    = Op[1] ? {{WIDTH{1'b0}}, src_a_mag} : {{WIDTH{1'b0}}, src_b_mag};
                    cnt_d    = '0;
                    state_d  = S_RUN;
                end else begin
                    if (HI_WE) hi_d = WD;
                    if (LO_WE) lo_d = WD;
                end
            end
            S_RUN: begin
                acc_d = is_div_q ? {div_rem, acc_q[WIDTH-2:0], div_ge}
                                 : {mul_sum, acc_q[WIDTH-1:1]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH-1)) state_d = S_FIN;
            end
            S_FIN: begin
                if (!is_div_q) begin
                    {hi_d, lo_d} = prod;
                end else if (b_q == '0) begin
                    // Divide by zero returns the original dividend in HI
                    lo_d = '1;
                    hi_d = neg_a_q ? -a_q : a_q;
                end else begin
                    lo_d = quo;
                    hi_d = rem;
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign Busy = (state_q != S_IDLE);
    assign Done = done_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule
